// File: rtl/pipe_adder.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : pipe_adder
// Brief    : Pipelined signed add/sub, one CLA segment per stage, valid/ready.
// Revision : 1.0
//------------------------------------------------------------------------------
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam int c_stages = WIDTH / SEG;
    localparam int c_mid    = (c_stages > 1) ? c_stages - 1 : 1;
    localparam int c_last   = c_stages - 1;
    localparam logic [WIDTH-1:0] c_seg_mask = WIDTH'((1 << SEG) - 1);

    // Result layout: {carry into segment MSB, carry out, SEG sum bits}
    function automatic logic [SEG+1:0] cla(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG:0]   c;
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic             w_advance;
    logic             w_v   [c_stages];
    logic [WIDTH-1:0] w_a   [c_stages];
    logic [WIDTH-1:0] w_b   [c_stages];
    logic             w_c   [c_stages];
    logic [WIDTH-1:0] w_s   [c_stages];
    logic [SEG+1:0]   w_add [c_stages];
    logic [WIDTH-1:0] w_sn  [c_stages];

    logic             r_v [c_mid];
    logic [WIDTH-1:0] r_a [c_mid];
    logic [WIDTH-1:0] r_b [c_mid];
    logic             r_c [c_mid];
    logic [WIDTH-1:0] r_s [c_mid];

    assign w_advance = !out_valid | out_ready;
    assign in_ready  = w_advance;

    assign w_v[0] = in_valid;
    assign w_a[0] = a;
    assign w_b[0] = sub ? ~b : b;
    assign w_c[0] = sub ? ~cin : cin;
    assign w_s[0] = '0;

    generate
        for (genvar k = 0; k < c_stages; k++) begin : g_stage
            assign w_add[k] = cla(w_a[k][k*SEG +: SEG], w_b[k][k*SEG +: SEG], w_c[k]);
            assign w_sn[k]  = (w_s[k] & ~(c_seg_mask << (k*SEG)))
                            | (WIDTH'(w_add[k][SEG-1:0]) << (k*SEG));

            if (k > 0) begin : g_feed
                assign w_v[k] = r_v[k-1];
                assign w_a[k] = r_a[k-1];
                assign w_b[k] = r_b[k-1];
                assign w_c[k] = r_c[k-1];
                assign w_s[k] = r_s[k-1];
            end

            // Upper operand segments ride along until their stage consumes them
            if (k < c_last) begin : g_mid
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_v[k] <= 1'b0;
                        r_a[k] <= '0;
                        r_b[k] <= '0;
                        r_c[k] <= 1'b0;
                        r_s[k] <= '0;
                    end else if (w_advance) begin
                        r_v[k] <= w_v[k];
                        r_a[k] <= w_a[k];
                        r_b[k] <= w_b[k];
                        r_c[k] <= w_add[k][SEG];
                        r_s[k] <= w_sn[k];
                    end
                end
            end
        end
    endgenerate

    logic             w_ovf;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_s_next;

    assign w_ovf     = w_add[c_last][SEG+1] ^ w_add[c_last][SEG];
    assign w_sat_val = w_a[c_last][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_s_next  = ((SAT != 0) && w_ovf) ? w_sat_val : w_sn[c_last];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            s          <= '0;
            cout       <= 1'b0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (w_advance) begin
                out_valid <= w_v[c_last];
                s         <= w_s_next;
                cout      <= w_add[c_last][SEG];
                ovf       <= w_ovf;
            end
            // A new overflow takes priority over a simultaneous clear
            if (w_advance && w_v[c_last] && w_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_pipe_adder
// Brief    : Scoreboard bench for pipe_adder, saturating and wrapping builds.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_pipe_adder;

    typedef struct {
        logic [15:0] s_sat;
        logic [15:0] s_wrap;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic        ovf_clr = 1'b0;

    logic        in_ready_sat, out_valid_sat, cout_sat, ovf_sat, sticky_sat;
    logic        in_ready_wrp, out_valid_wrp, cout_wrp, ovf_wrp, sticky_wrp;
    logic [15:0] s_sat, s_wrp;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .SEG(4), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_sat),
        .out_ready(out_ready), .s(s_sat), .cout(cout_sat), .ovf(ovf_sat),
        .ovf_sticky(sticky_sat), .ovf_clr(ovf_clr)
    );

    pipe_adder #(.WIDTH(16), .SEG(4), .SAT(0)) dut_wrp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_wrp),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_wrp),
        .out_ready(out_ready), .s(s_wrp), .cout(cout_wrp), .ovf(ovf_wrp),
        .ovf_sticky(sticky_wrp), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [15:0] yp;
        logic        c0;
        logic [16:0] full;
        yp       = sb ? ~y : y;
        c0       = sb ? ~ci : ci;
        full     = {1'b0, x} + {1'b0, yp} + {16'd0, c0};
        e.cout   = full[16];
        e.ovf    = (x[15] == yp[15]) && (full[15] != x[15]);
        e.s_wrap = full[15:0];
        e.s_sat  = e.ovf ? (x[15] ? 16'h8000 : 16'h7FFF) : full[15:0];
        return e;
    endfunction

    // Called right at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic sb);
        int w = 0;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        #1;
        while (!in_ready_sat && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 50) check("accept_timeout", 0, 1);
        q.push_back(model(x, y, ci, sb));
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Output monitor, sampled mid-low-phase
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid_sat && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("s_sat", 32'(s_sat), 32'(e.s_sat));
                    check("s_wrap", 32'(s_wrp), 32'(e.s_wrap));
                    check("cout", 32'({cout_sat, cout_wrp}), 32'({e.cout, e.cout}));
                    check("ovf", 32'({ovf_sat, ovf_wrp}), 32'({e.ovf, e.ovf}));
                    check("valid_wrap", 32'(out_valid_wrp), 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          w;
        logic [15:0] held;
        int          seen;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'({out_valid_sat, out_valid_wrp}), 0);
        check("rst_sticky", 32'({sticky_sat, sticky_wrp}), 0);
        check("rst_s", 32'(s_sat), 0);
        check("rst_in_ready", 32'(in_ready_sat), 1);
        rst = 1'b0;
        @(negedge clk);

        // Basic add and latency
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        idle();
        lat = 1;
        while (!out_valid_sat && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 4);
        drain();

        send(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0003, 1'b1, 1'b1);
        idle();
        drain();
        check("sticky_clean", 32'({sticky_sat, sticky_wrp}), 0);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        idle();
        drain();
        check("sticky_set", 32'({sticky_sat, sticky_wrp}), 32'b11);

        // Same-cycle set beats clear; clear alone drops it
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("sticky_cleared", 32'({sticky_sat, sticky_wrp}), 0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        check("clr_race_valid", 32'(out_valid_sat), 1);
        check("clr_race_sticky", 32'({sticky_sat, sticky_wrp}), 32'b11);
        @(negedge clk);
        check("clr_next_sticky", 32'({sticky_sat, sticky_wrp}), 0);
        ovf_clr = 1'b0;
        drain();

        // Random stream with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                idle();
            end
            begin
                w = 0;
                while (!out_valid_sat && w < 30) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 30) check("stream_timeout", 0, 1);
                @(negedge clk);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("stall_in_ready", 32'(in_ready_sat), 0);
                    if (i == 0) held = s_sat;
                    else check("stall_s_held", 32'(s_sat), 32'(held));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_all_out", 32'(q.size()), 0);

        // Reset with operands in flight
        out_ready = 1'b0;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        idle();
        w = 0;
        while (!out_valid_sat && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("pre_rst_valid", 32'(out_valid_sat), 1);
        check("pre_rst_sticky", 32'(sticky_sat), 1);
        rst = 1'b1;
        q.delete();
        #1;
        check("mid_rst_valid", 32'({out_valid_sat, out_valid_wrp}), 0);
        check("mid_rst_sticky", 32'({sticky_sat, sticky_wrp}), 0);
        check("mid_rst_ovf", 32'({ovf_sat, ovf_wrp}), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid_sat || out_valid_wrp) seen++;
        end
        check("post_rst_silent", 32'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
